// File: rtl/clb_chain_pkg.sv
// Shared types and constants for the slice-serial adder controller.
// Imported by clb_chain_cell, clb_chain_ctrl and clb_chain_top.
package clb_chain_pkg;

  localparam int SLICE_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Signed overflow: same-sign operands whose sum flips sign.
  function automatic logic ovf_of(
    input logic a_msb,
    input logic b_msb,
    input logic s_msb
  );
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/clb_chain_cell.sv
// Registered 2-bit adder cell; sum and carry appear one edge after inputs.
// Stateless apart from the output register, cleared by reset.
module clb_chain_cell
  import clb_chain_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               c_in,
  input  logic [SLICE_W-1:0] input_1,
  input  logic [SLICE_W-1:0] input_2,
  output logic [SLICE_W-1:0] sum,
  output logic               c_out
);

  logic [SLICE_W:0] res_q;
  logic [SLICE_W:0] res_d;

  // Combinational slice add.
  always_comb begin
    res_d = {1'b0, input_1} + {1'b0, input_2}
          + {{SLICE_W{1'b0}}, c_in};
  end

  // Register the slice result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) res_q <= '0;
    else       res_q <= res_d;
  end

  assign sum   = res_q[SLICE_W-1:0];
  assign c_out = res_q[SLICE_W];

endmodule

// File: rtl/clb_chain_top.sv
// Integration wrapper: controller plus one registered adder cell.
// Exposes out_ovf when CLB_CHAIN_OVF_EN is defined.
module clb_chain_top
  import clb_chain_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
`ifdef CLB_CHAIN_OVF_EN
  output logic             out_ovf,
`endif
  output logic             out_cout
);

  logic               c_in;
  logic [SLICE_W-1:0] op1;
  logic [SLICE_W-1:0] op2;
  logic [SLICE_W-1:0] s;
  logic               c_out;

  clb_chain_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_cin      (in_cin),
    .clb_c_in    (c_in),
    .clb_input_1 (op1),
    .clb_input_2 (op2),
    .clb_sum     (s),
    .clb_c_out   (c_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
`ifdef CLB_CHAIN_OVF_EN
    .out_ovf     (out_ovf),
`endif
    .out_cout    (out_cout)
  );

  clb_chain_cell u_cell (
    .clock   (clock),
    .reset   (reset),
    .c_in    (c_in),
    .input_1 (op1),
    .input_2 (op2),
    .sum     (s),
    .c_out   (c_out)
  );

endmodule

// File: rtl/clb_chain_ctrl.sv
// Sequences a WIDTH-bit add through an external registered 2-bit cell.
// Optional out_ovf port when CLB_CHAIN_OVF_EN is defined.
module clb_chain_ctrl
  import clb_chain_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             clb_c_in,
  output logic [1:0]       clb_input_1,
  output logic [1:0]       clb_input_2,
  input  logic [1:0]       clb_sum,
  input  logic             clb_c_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
`ifdef CLB_CHAIN_OVF_EN
  output logic             out_ovf,
`endif
  output logic             out_cout
);

  localparam int SLICES = WIDTH / 2;
  localparam int CW     = $clog2(SLICES + 1);
  localparam logic [CW-1:0] LAST = CW'(SLICES);

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("clb_chain_ctrl: WIDTH must be even and >= 4");
  end

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef CLB_CHAIN_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Next-state, operand latch and result demux.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef CLB_CHAIN_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          cin_d   = in_cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        // Cell output lags by one edge: slice cnt-1 lands now.
        for (int i = 1; i <= SLICES; i++) begin
          if (cnt_q == CW'(i)) begin
            sum_d[(i-1)*SLICE_W +: SLICE_W] = clb_sum;
          end
        end
        if (cnt_q == LAST) begin
          cout_d  = clb_c_out;
          cnt_d   = '0;
          state_d = DONE;
`ifdef CLB_CHAIN_OVF_EN
          ovf_d   = ovf_of(a_q[WIDTH-1], b_q[WIDTH-1],
                           clb_sum[SLICE_W-1]);
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Slice presentation to the cell; idle outside RUN.
  always_comb begin
    clb_input_1 = '0;
    clb_input_2 = '0;
    clb_c_in    = 1'b0;
    if (state_q == RUN) begin
      for (int i = 0; i < SLICES; i++) begin
        if (cnt_q == CW'(i)) begin
          clb_input_1 = a_q[i*SLICE_W +: SLICE_W];
          clb_input_2 = b_q[i*SLICE_W +: SLICE_W];
          // Slice 0 never uses stale cell carry.
          clb_c_in    = (i == 0) ? cin_q : clb_c_out;
        end
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef CLB_CHAIN_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef CLB_CHAIN_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
`ifdef CLB_CHAIN_OVF_EN
  assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_clb_chain_ctrl.sv
// Directed bench for clb_chain_ctrl with a behavioural 2-bit cell.
// Build with CLB_CHAIN_OVF_EN defined to also check out_ovf.
module tb_clb_chain_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic       in_cin = 1'b0;
  logic       clb_c_in;
  logic [1:0] clb_input_1;
  logic [1:0] clb_input_2;
  logic [1:0] clb_sum;
  logic       clb_c_out;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_sum;
  logic       out_cout;
`ifdef CLB_CHAIN_OVF_EN
  logic       out_ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  clb_chain_ctrl #(.WIDTH(8)) dut (
    .clock       (clk),
    .reset       (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_cin      (in_cin),
    .clb_c_in    (clb_c_in),
    .clb_input_1 (clb_input_1),
    .clb_input_2 (clb_input_2),
    .clb_sum     (clb_sum),
    .clb_c_out   (clb_c_out),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
`ifdef CLB_CHAIN_OVF_EN
    .out_ovf     (out_ovf),
`endif
    .out_cout    (out_cout)
  );

  // Behavioural registered 2-bit adder cell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) {clb_c_out, clb_sum} <= 3'd0;
    else     {clb_c_out, clb_sum} <= {1'b0, clb_input_1}
                                   + {1'b0, clb_input_2}
                                   + {2'b0, clb_c_in};
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [7:0] a,
                     input logic [7:0] b,
                     input logic c,
                     input logic [7:0] es,
                     input logic ec,
                     input logic eo,
                     input int hold,
                     input string tag);
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_cin = c;
    chk({tag, ".rdy_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({tag, ".s0_op1"}, 32'(clb_input_1), 32'(a[1:0]));
    chk({tag, ".s0_op2"}, 32'(clb_input_2), 32'(b[1:0]));
    chk({tag, ".s0_cin"}, 32'(clb_c_in), 32'(c));
    lat = 0;
    while (!out_valid && lat < 20) begin
      chk({tag, ".rdy_run"}, 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'd5);
    chk({tag, ".sum"}, 32'(out_sum), 32'(es));
    chk({tag, ".cout"}, 32'(out_cout), 32'(ec));
`ifdef CLB_CHAIN_OVF_EN
    chk({tag, ".ovf"}, 32'(out_ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("unexpected x");
`endif
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_vld"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_sum"}, 32'(out_sum), 32'(es));
      chk({tag, ".hold_cout"}, 32'(out_cout), 32'(ec));
      chk({tag, ".hold_rdy"}, 32'(in_ready), 32'd0);
      chk({tag, ".hold_op1"}, 32'(clb_input_1), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".vld_drop"}, 32'(out_valid), 32'd0);
    chk({tag, ".rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int seen;
    #1;
    chk("rst.rdy", 32'(in_ready), 32'd0);
    chk("rst.vld", 32'(out_valid), 32'd0);
    chk("rst.sum", 32'(out_sum), 32'd0);
    chk("rst.cout", 32'(out_cout), 32'd0);
    chk("rst.op1", 32'(clb_input_1), 32'd0);
    chk("rst.op2", 32'(clb_input_2), 32'd0);
    chk("rst.cin", 32'(clb_c_in), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel.rdy", 32'(in_ready), 32'd1);

    run(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0, "t5a3c");
    run(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0, "tff01");
    run(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0, "tffff");
    run(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 3, "thold");
    run(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0, "t7f01");
    run(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0, "t8080");

    @(negedge clk);
    in_valid = 1'b1;
    in_a = 8'hC3;
    in_b = 8'h3C;
    in_cin = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid.op1", 32'(clb_input_1), 32'd0);
    rst = 1'b1;
    #1;
    chk("abort.rdy", 32'(in_ready), 32'd0);
    chk("abort.vld", 32'(out_valid), 32'd0);
    chk("abort.sum", 32'(out_sum), 32'd0);
    chk("abort.cout", 32'(out_cout), 32'd0);
    chk("abort.op1", 32'(clb_input_1), 32'd0);
    chk("abort.op2", 32'(clb_input_2), 32'd0);
    chk("abort.cin", 32'(clb_c_in), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort.rdy_rel", 32'(in_ready), 32'd1);
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("abort.no_vld", 32'(seen), 32'd0);
    run(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0, "t1020");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clb_chain_ctrl.md
CLB_CHAIN_CTRL -- requirements
Module: clb_chain_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; must be even and at least 4.
REQ-002 SHALL have derived localparam SLICES = WIDTH/2, the number of 2-bit slices per operand.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all state updates on posedge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: request present.
REQ-006 SHALL have port in_ready, output, 1 bit: request accepted when in_valid && in_ready at posedge.
REQ-007 SHALL have ports in_a and in_b, input, WIDTH bits each: unsigned operands.
REQ-008 SHALL have port in_cin, input, 1 bit: carry into slice 0.
REQ-009 SHALL have port clb_c_in, output, 1 bit: carry driven to the registered 2-bit adder cell.
REQ-010 SHALL have ports clb_input_1 and clb_input_2, output, 2 bits each: slice operands to the cell.
REQ-011 SHALL have port clb_sum, input, 2 bits: registered slice sum returned from the cell.
REQ-012 SHALL have port clb_c_out, input, 1 bit: registered slice carry returned from the cell.
REQ-013 SHALL have port out_valid, output, 1 bit: result available.
REQ-014 SHALL have port out_ready, input, 1 bit: result consumed when out_valid && out_ready at posedge.
REQ-015 SHALL have port out_sum, output, WIDTH bits: assembled sum.
REQ-016 SHALL have port out_cout, output, 1 bit: final carry out.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 In IDLE SHALL assert in_ready=1; on accept SHALL latch in_a, in_b and in_cin, clear slice counter cnt to 0, and go to RUN.
REQ-019 In RUN with cnt<SLICES SHALL drive clb_input_1 = a[2*cnt+1:2*cnt] and clb_input_2 = b[2*cnt+1:2*cnt].
REQ-020 In RUN with cnt<SLICES SHALL drive clb_c_in = latched cin when cnt==0, and clb_c_in = clb_c_out otherwise.
REQ-021 In RUN with cnt>0 SHALL capture clb_sum into result slice cnt-1 at the posedge.
REQ-022 In RUN SHALL increment cnt by 1 per cycle.
REQ-023 In RUN with cnt==SLICES SHALL capture the last slice and out_cout = clb_c_out, and go to DONE.
REQ-024 Outside RUN slice presentation SHALL drive clb_input_1, clb_input_2 and clb_c_in to 0.
REQ-025 Latency: out_valid SHALL rise exactly SLICES+1 posedges after the accepting posedge (5 for WIDTH=8); throughput SHALL be one slice per cycle.
REQ-026 In DONE SHALL hold out_valid=1 with out_sum and out_cout stable until out_ready; on consume SHALL return to IDLE.
REQ-027 SHALL deassert in_ready in RUN and DONE; no overlap of transactions.
REQ-028 SHALL set out_sum = (in_a + in_b + in_cin) mod 2^WIDTH and out_cout = bit WIDTH of that sum.
REQ-029 Result registers SHALL NOT change while in DONE, regardless of clb_* inputs.

Reset
REQ-030 While reset=1, SHALL hold state=IDLE, cnt=0, in_ready=0, out_valid=0, out_sum=0, out_cout=0 and all clb_* outputs=0.
REQ-031 in_ready SHALL become 1 in the first cycle after reset deasserts.
REQ-032 Reset during RUN or DONE SHALL abort and discard the transaction; no out_valid pulse SHALL follow.
REQ-033 Correctness SHALL NOT depend on cell state left from a prior transaction, because slice 0 always uses the latched cin.

Configuration
REQ-034 With macro CLB_CHAIN_OVF_EN defined, SHALL add output out_ovf (1 bit), registered in DONE, = (a[W-1]==b[W-1]) && (out_sum[W-1]!=a[W-1]); out_ovf SHALL reset to 0.
REQ-035 Without CLB_CHAIN_OVF_EN, port out_ovf and its logic SHALL be absent.

Structure
REQ-036 Package clb_chain_pkg SHALL hold the state enum (IDLE/RUN/DONE) and constant SLICE_W=2.
REQ-037 The module SHALL contain no sub-module; slice mux and demux are inline.
REQ-038 Integration wrapper clb_chain_top SHALL instantiate clb_chain_ctrl plus one adder cell, sharing clock and reset.

Verification
REQ-039 WIDTH=8: a=0x5A, b=0x3C, cin=0 -> out_sum=0x96, out_cout=0, out_valid 5 edges after accept.
REQ-040 a=0xFF, b=0x01, cin=0 -> out_sum=0x00, out_cout=1 (full carry ripple across 4 slices).
REQ-041 a=0xFF, b=0xFF, cin=1 -> out_sum=0xFF, out_cout=1; in_ready=0 throughout RUN/DONE.
REQ-042 Hold out_ready=0 for 3 cycles in DONE -> out_valid and out_sum held; consume -> in_ready=1 next cycle.
REQ-043 Assert reset at cnt=2 -> all outputs 0 immediately; next request 0x10+0x20 -> 0x30, cout=0.
REQ-044 With CLB_CHAIN_OVF_EN: 0x7F+0x01 -> out_ovf=1, and 0x80+0x80 -> out_ovf=1, out_cout=1.
